addr8u_sched: RTL and testbench

ADDR8U_SCHED -- requirements
Module: addr8u_sched

---
 rtl/addr8u_sched_pkg.sv | 25 ++
 rtl/addr8u_sched_if.sv | 33 +++
 rtl/addr8u_rr_arb.sv | 46 ++++
 rtl/addr8u_sched.sv | 161 ++++++++++++++++
 tb/tb_addr8u_sched.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/addr8u_sched_pkg.sv
// Shared types and widths for the addr8u_sched shared-adder scheduler.
// The CHK/retry path is present only when ADDR8U_SCHED_RECHECK_EN is defined.
package addr8u_sched_pkg;

  localparam int OP_W  = 8;
  localparam int SUM_W = 9;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP1  = 2'd1,
    CHK  = 2'd2,
    RESP = 2'd3
  } state_e;

  // Round-robin pointer advance: one past the winner, wrapping at num_req.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] idx,
                                               input int num_req);
    logic [ID_W-1:0] nxt;
    if (int'(idx) == num_req - 1) nxt = '0;
    else                          nxt = idx + 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/addr8u_sched_if.sv
// Bundle of the addr8u_sched request, adder and response signals.
// Handshake: a response transfers on a rising edge where rsp_valid && rsp_ready; rsp_* hold stable while rsp_valid && !rsp_ready.
interface addr8u_sched_if #(
  parameter int NUM_REQ = 4
) ();
  import addr8u_sched_pkg::*;

  logic [NUM_REQ-1:0]      req;
  logic [OP_W*NUM_REQ-1:0] op_a;
  logic [OP_W*NUM_REQ-1:0] op_b;
  logic [NUM_REQ-1:0]      gnt;
  logic [OP_W-1:0]         add_a;
  logic [OP_W-1:0]         add_b;
  logic [SUM_W-1:0]        add_s;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [SUM_W-1:0]        rsp_sum;
  logic [ID_W-1:0]         rsp_id;
  logic                    rsp_err;

  // Requesters, external adder and response consumer.
  modport master (
    output req, op_a, op_b, add_s, rsp_ready,
    input  gnt, add_a, add_b, rsp_valid, rsp_sum, rsp_id, rsp_err
  );

  // The scheduler.
  modport slave (
    input  req, op_a, op_b, add_s, rsp_ready,
    output gnt, add_a, add_b, rsp_valid, rsp_sum, rsp_id, rsp_err
  );

endinterface

// File: rtl/addr8u_rr_arb.sv
// Combinational round-robin arbiter: searches from ptr_i upward with wrap.
// Returns a one-hot grant, the winner index and a valid flag.
module addr8u_rr_arb
  import addr8u_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               valid_o
);

  localparam logic [ID_W:0]      NUM_L = (ID_W + 1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE   = NUM_REQ'(1);

  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      sum_w;
  logic               found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    off   = '0;
    found = 1'b0;
    // Rotate so bit 0 is the pointer position; lowest set bit wins.
    rot   = NUM_REQ'({req_i, req_i} >> ptr_i);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = k[ID_W-1:0];
      end
    end
    sum_w = {1'b0, ptr_i} + {1'b0, off};
    if (sum_w >= NUM_L) sum_w = sum_w - NUM_L;
    if (found) begin
      idx_o = sum_w[ID_W-1:0];
      gnt_o = ONE << idx_o;
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/addr8u_sched.sv
// Round-robin scheduler sharing one external 8-bit adder among NUM_REQ requesters.
// Define ADDR8U_SCHED_RECHECK_EN to add the commutative recompute check (CHK) with MAX_RETRY retries.
module addr8u_sched
  import addr8u_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [OP_W*NUM_REQ-1:0] op_a,
  input  logic [OP_W*NUM_REQ-1:0] op_b,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [OP_W-1:0]         add_a,
  output logic [OP_W-1:0]         add_b,
  input  logic [SUM_W-1:0]        add_s,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [SUM_W-1:0]        rsp_sum,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_err,
  output state_e                  dbg_state
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [SUM_W-1:0]  s1_q, s1_d;
  logic [NUM_REQ-1:0] gnt_c;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_valid;

`ifdef ADDR8U_SCHED_RECHECK_EN
  localparam logic [2:0] MAX_RETRY_L = 3'(MAX_RETRY);
  logic [2:0] retry_q, retry_d;
  logic       err_q, err_d;
`else
  logic unused_max_retry;
  assign unused_max_retry = ^3'(MAX_RETRY);
`endif

  addr8u_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    s1_d    = s1_q;
    gnt_c   = '0;
    add_a   = '0;
    add_b   = '0;
`ifdef ADDR8U_SCHED_RECHECK_EN
    retry_d = retry_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_c = arb_gnt;
          for (int j = 0; j < NUM_REQ; j++) begin
            if (arb_gnt[j]) begin
              a_d = op_a[j*OP_W +: OP_W];
              b_d = op_b[j*OP_W +: OP_W];
            end
          end
          id_d    = arb_idx;
          ptr_d   = rr_next(arb_idx, NUM_REQ);
          state_d = OP1;
`ifdef ADDR8U_SCHED_RECHECK_EN
          retry_d = '0;
          err_d   = 1'b0;
`endif
        end
      end
      OP1: begin
        add_a = a_q;
        add_b = b_q;
        s1_d  = add_s;
`ifdef ADDR8U_SCHED_RECHECK_EN
        state_d = CHK;
`else
        state_d = RESP;
`endif
      end
      CHK: begin
`ifdef ADDR8U_SCHED_RECHECK_EN
        // Swapped operands catch faults that are not symmetric in the adder inputs.
        add_a = b_q;
        add_b = a_q;
        if (add_s == s1_q) begin
          state_d = RESP;
        end else if (retry_q < MAX_RETRY_L) begin
          retry_d = retry_q + 3'd1;
          state_d = OP1;
        end else begin
          err_d   = 1'b1;
          state_d = RESP;
        end
`else
        state_d = IDLE;
`endif
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      s1_q    <= '0;
`ifdef ADDR8U_SCHED_RECHECK_EN
      retry_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      s1_q    <= s1_d;
`ifdef ADDR8U_SCHED_RECHECK_EN
      retry_q <= retry_d;
      err_q   <= err_d;
`endif
    end
  end

  // The grant is combinational from req, so it is gated while reset is held.
  assign gnt       = rst_n ? gnt_c : '0;
  assign rsp_valid = (state_q == RESP);
  assign rsp_sum   = rsp_valid ? s1_q : '0;
  assign rsp_id    = rsp_valid ? id_q : '0;
`ifdef ADDR8U_SCHED_RECHECK_EN
  assign rsp_err   = rsp_valid & err_q;
`else
  assign rsp_err   = 1'b0;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_addr8u_sched.sv
// Self-checking bench for addr8u_sched: vector table, reset/retry/backpressure sequences, random phase.
// Expected responses are queued at grant time and compared when rsp_valid appears.
module tb_addr8u_sched;
  import addr8u_sched_pkg::*;

  localparam int N = 4;
`ifdef ADDR8U_SCHED_RECHECK_EN
  localparam int         LAT_OK = 3;
  localparam logic [7:0] MID_A  = 8'h44;
`else
  localparam int         LAT_OK = 2;
  localparam logic [7:0] MID_A  = 8'h33;
`endif

  logic   clk;
  logic   rst_n;
  state_e dbg_state;
  logic   corrupt;
  int     n_checks;
  int     n_pass;
  int     ptr_m;
  int     op1_cnt = 0;

  logic [12:0] exp_q[$];

  addr8u_sched_if #(.NUM_REQ(N)) bus ();

  addr8u_sched #(.NUM_REQ(N), .MAX_RETRY(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.req),
    .op_a      (bus.op_a),
    .op_b      (bus.op_b),
    .gnt       (bus.gnt),
    .add_a     (bus.add_a),
    .add_b     (bus.add_b),
    .add_s     (bus.add_s),
    .rsp_valid (bus.rsp_valid),
    .rsp_ready (bus.rsp_ready),
    .rsp_sum   (bus.rsp_sum),
    .rsp_id    (bus.rsp_id),
    .rsp_err   (bus.rsp_err),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External adder model; corrupts only the swapped-operand recompute of 0x10/0x20.
  always_comb begin
    bus.add_s = {1'b0, bus.add_a} + {1'b0, bus.add_b};
    if (corrupt && bus.add_a == 8'h20 && bus.add_b == 8'h10) bus.add_s = 9'h055;
  end

  always @(posedge clk) begin
    if (bus.add_a == 8'h10 && bus.add_b == 8'h20) op1_cnt <= op1_cnt + 1;
  end

  typedef struct {
    logic [3:0]  req;
    logic [31:0] oa;
    logic [31:0] ob;
    logic [3:0]  busy_req;
    int          hold;
    logic [3:0]  gnt;
    logic [8:0]  sum;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [2:0] onehot_idx(input logic [3:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction

  function automatic int rr_pick(input logic [3:0] m, input int p);
    int w;
    w = -1;
    for (int k = N - 1; k >= 0; k--) if (m[(p + k) % N]) w = (p + k) % N;
    return w;
  endfunction

  // Driver task: one complete transaction from grant through handshake.
  task automatic do_txn(input logic [3:0] mask, input logic [31:0] oa, input logic [31:0] ob,
                        input logic [3:0] busy_req, input int hold, input logic [3:0] exp_gnt,
                        input logic [8:0] exp_sum, input logic exp_err, input int exp_lat,
                        input string tag);
    int          lat;
    logic        got;
    logic        busy_gnt;
    logic        stable;
    logic [12:0] exp_w;
    logic [12:0] snap;
    @(negedge clk);
    bus.req       = mask;
    bus.op_a      = oa;
    bus.op_b      = ob;
    bus.rsp_ready = (hold == 0);
    #1;
    check({tag, ".gnt"}, 32'(bus.gnt), 32'(exp_gnt));
    exp_q.push_back({exp_sum, onehot_idx(exp_gnt), exp_err});
    lat = 0;
    got = 1'b0;
    busy_gnt = 1'b0;
    repeat (40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.req  = (mask & ~exp_gnt) | busy_req;
        bus.op_a = $urandom;
        bus.op_b = $urandom;
      end
      #1;
      if (bus.gnt != '0) busy_gnt = 1'b1;
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, ".no_gnt_busy"}, 32'(busy_gnt), 32'd0);
    if (!got) begin
      check({tag, ".rsp_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else begin
      check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      check({tag, ".adder_idle"}, 32'({bus.add_a, bus.add_b}), 32'd0);
      exp_w = exp_q.pop_front();
      check({tag, ".sum"}, 32'(bus.rsp_sum), 32'(exp_w[12:4]));
      check({tag, ".id"},  32'(bus.rsp_id),  32'(exp_w[3:1]));
      check({tag, ".err"}, 32'(bus.rsp_err), 32'(exp_w[0]));
      bus.req = mask & ~exp_gnt;
      if (hold > 0) begin
        stable = 1'b1;
        snap   = {bus.rsp_sum, bus.rsp_id, bus.rsp_err};
        for (int k = 0; k < hold; k++) begin
          @(negedge clk);
          #1;
          if (!bus.rsp_valid || {bus.rsp_sum, bus.rsp_id, bus.rsp_err} != snap || bus.gnt != '0)
            stable = 1'b0;
        end
        check({tag, ".hold_stable"}, 32'(stable), 32'd1);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        check({tag, ".hs_no_gnt"}, 32'(bus.gnt), 32'd0);
      end
    end
  endtask

  initial begin
    logic       idle_bad;
    int         op1_before;
    logic [3:0] m;
    logic [31:0] oa;
    logic [31:0] ob;
    logic [8:0] es;
    int         w;

    n_checks = 0;
    n_pass   = 0;
    corrupt  = 1'b0;

    vt[0]  = '{4'b1111, 32'h44332211, 32'h0FAAF001, 4'b0000, 0, 4'b0001, 9'h012};
    vt[1]  = '{4'b1111, 32'h44332211, 32'h0FAAF001, 4'b0000, 0, 4'b0010, 9'h112};
    vt[2]  = '{4'b1111, 32'h44332211, 32'h0FAAF001, 4'b0000, 0, 4'b0100, 9'h0DD};
    vt[3]  = '{4'b1111, 32'h44332211, 32'h0FAAF001, 4'b0000, 0, 4'b1000, 9'h053};
    vt[4]  = '{4'b1111, 32'h44332211, 32'h0FAAF001, 4'b0000, 0, 4'b0001, 9'h012};
    vt[5]  = '{4'b0001, 32'h000000FF, 32'h00000001, 4'b0000, 0, 4'b0001, 9'h100};
    vt[6]  = '{4'b1001, 32'hC0000001, 32'h7F000002, 4'b0000, 0, 4'b1000, 9'h13F};
    vt[7]  = '{4'b0110, 32'h00ABCD00, 32'h0001FE00, 4'b0000, 0, 4'b0010, 9'h1CB};
    vt[8]  = '{4'b0011, 32'h00007700, 32'h00008800, 4'b0000, 0, 4'b0001, 9'h000};
    vt[9]  = '{4'b1000, 32'h80000000, 32'h80000000, 4'b0000, 0, 4'b1000, 9'h100};
    vt[10] = '{4'b0100, 32'h00FF0000, 32'h00FF0000, 4'b0000, 0, 4'b0100, 9'h1FE};
    vt[11] = '{4'b0011, 32'h0000005A, 32'h000000A5, 4'b0000, 5, 4'b0001, 9'h0FF};
    vt[12] = '{4'b0010, 32'h00000100, 32'h0000FF00, 4'b0000, 0, 4'b0010, 9'h100};
    vt[13] = '{4'b0100, 32'h00070000, 32'h00090000, 4'b1000, 0, 4'b0100, 9'h010};
    vt[14] = '{4'b0001, 32'h000000FE, 32'h000000FE, 4'b0000, 0, 4'b0001, 9'h1FC};

    // Reset state, with requests already asserted.
    rst_n         = 1'b0;
    bus.req       = 4'b1111;
    bus.op_a      = $urandom;
    bus.op_b      = $urandom;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst.gnt",       32'(bus.gnt),       32'd0);
    check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst.add_a",     32'(bus.add_a),     32'd0);
    check("rst.add_b",     32'(bus.add_b),     32'd0);
    check("rst.rsp_sum",   32'(bus.rsp_sum),   32'd0);
    check("rst.rsp_id",    32'(bus.rsp_id),    32'd0);
    check("rst.rsp_err",   32'(bus.rsp_err),   32'd0);
    check("rst.state",     32'(dbg_state),     32'(IDLE));
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 4'b0000;
    #1;
    check("idle.no_req_gnt", 32'(bus.gnt), 32'd0);

    for (int i = 0; i < 15; i++) begin
      do_txn(vt[i].req, vt[i].oa, vt[i].ob, vt[i].busy_req, vt[i].hold, vt[i].gnt,
             vt[i].sum, 1'b0, LAT_OK, $sformatf("vec%0d", i));
    end

`ifdef ADDR8U_SCHED_RECHECK_EN
    // Recompute always disagrees: three OP1/CHK passes, then an error response.
    corrupt    = 1'b1;
    op1_before = op1_cnt;
    do_txn(4'b0010, 32'h00001000, 32'h00002000, 4'b0000, 0, 4'b0010, 9'h030, 1'b1, 7, "retry");
    check("retry.op1_passes", 32'(op1_cnt - op1_before), 32'd3);
    corrupt = 1'b0;
`else
    op1_before = op1_cnt;
`endif

    // Reset in the middle of a transaction.
    @(negedge clk);
    bus.req       = 4'b0100;
    bus.op_a      = 32'h00330000;
    bus.op_b      = 32'h00440000;
    bus.rsp_ready = 1'b1;
    #1;
    check("mid.gnt", 32'(bus.gnt), 32'b0100);
    @(negedge clk);
    bus.req = 4'b0000;
`ifdef ADDR8U_SCHED_RECHECK_EN
    @(negedge clk);
`endif
    #1;
    check("mid.add_a", 32'(bus.add_a), 32'(MID_A));
    #1;
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    #1;
    check("mid_rst.gnt",       32'(bus.gnt),       32'd0);
    check("mid_rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst.add",       32'({bus.add_a, bus.add_b}), 32'd0);
    check("mid_rst.rsp_data",  32'({bus.rsp_sum, bus.rsp_id, bus.rsp_err}), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 4'b0000;
    idle_bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid || bus.gnt != '0) idle_bad = 1'b1;
    end
    check("mid_rst.no_response", 32'(idle_bad), 32'd0);
    do_txn(4'b1010, 32'h00009C00, 32'h00006400, 4'b0000, 0, 4'b0010, 9'h100, 1'b0, LAT_OK, "post_rst");
    ptr_m = 2;

    // Random phase against the round-robin reference.
    for (int n = 0; n < 20; n++) begin
      m  = 4'($urandom_range(1, 15));
      oa = $urandom;
      ob = $urandom;
      w  = rr_pick(m, ptr_m);
      es = {1'b0, oa[8*w +: 8]} + {1'b0, ob[8*w +: 8]};
      do_txn(m, oa, ob, 4'b0000, $urandom_range(0, 2), 4'(1 << w), es, 1'b0, LAT_OK,
             $sformatf("rnd%0d", n));
      ptr_m = (w + 1) % N;
    end

    check("scoreboard.empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
